// File: rtl/ddr_wr_burst_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ddr_wr_burst_ctrl
// Drains the prefetch (FWFT) read side of the DDR write FIFO and issues
// fixed-length AXI4 INCR write bursts to the DDR controller user port.
// Burst addresses step through a frame buffer starting at BASE_ADDR and wrap
// back to BASE_ADDR once FRAME_BEATS beats have been written.
//
// Ports:
//   clk, rst_n            DDR user clock (also FIFO read clock), async reset
//   enable                allow new bursts to start
//   frame_start           pulse: restart addressing at BASE_ADDR
//   fifo_rd_en            FIFO pop (same cycle as the W handshake)
//   fifo_rd_data          FIFO head word, valid while !fifo_empty
//   fifo_empty            FIFO empty flag
//   fifo_rd_level         FIFO read water level in words
//   m_aw*                 AXI write address channel (master)
//   m_w*                  AXI write data channel (master)
//   m_b*                  AXI write response channel (master)
//   busy                  controller not idle
//   frame_done            one-cycle pulse after the last response of a frame
//   resp_err              sticky error flag, set on any non-OKAY response
// ---------------------------------------------------------------------------
module ddr_wr_burst_ctrl #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH  = 28,
    parameter int unsigned LVL_WIDTH   = 8,
    parameter int unsigned BURST_LEN   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned FRAME_BEATS = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    frame_start,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_empty,
    input  logic [LVL_WIDTH-1:0]    fifo_rd_level,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    resp_err
);

    localparam int unsigned STRB_W      = DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * STRB_W;
    localparam int unsigned FRM_W       = $clog2(FRAME_BEATS + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [FRM_W-1:0]      FRM_STEP  = FRM_W'(BURST_LEN);
    localparam logic [FRM_W-1:0]      FRM_END   = FRM_W'(FRAME_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [FRM_W-1:0]        r_frm_cnt;
    logic [7:0]              r_beat_cnt;
    logic                    r_fs_pend;
    logic                    r_frame_done;
    logic                    r_resp_err;

    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   w_cur_addr_nxt;
    logic [FRM_W-1:0]        w_frm_cnt_nxt;
    logic [7:0]              w_beat_cnt_nxt;
    logic                    w_fs_pend_nxt;
    logic                    w_frame_done_nxt;
    logic                    w_resp_err_nxt;
    logic                    w_wvalid;
    logic                    w_wlast;
    logic                    w_rd_en;
    logic [FRM_W-1:0]        w_frm_sum;
    logic                    w_frm_wrap;
    logic                    w_level_ok;

    // Enough words buffered for a whole burst, so W never starves by design
    assign w_level_ok = (32'(fifo_rd_level) >= BURST_LEN);

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cur_addr   <= BASE_ADDR;
            r_frm_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_fs_pend    <= 1'b0;
            r_frame_done <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_frm_cnt    <= w_frm_cnt_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_fs_pend    <= w_fs_pend_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    // Next-state, address/frame bookkeeping and W-channel handshake
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_addr_nxt   = r_cur_addr;
        w_frm_cnt_nxt    = r_frm_cnt;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_fs_pend_nxt    = r_fs_pend;
        w_frame_done_nxt = 1'b0;
        w_resp_err_nxt   = r_resp_err;
        w_wvalid         = 1'b0;
        w_wlast          = 1'b0;
        w_rd_en          = 1'b0;
        w_frm_sum        = r_frm_cnt + FRM_STEP;
        w_frm_wrap       = (w_frm_sum >= FRM_END);

        case (r_state)
            ST_IDLE: begin
                // A frame restart takes the whole cycle; the burst waits one
                if (frame_start) begin
                    w_cur_addr_nxt = BASE_ADDR;
                    w_frm_cnt_nxt  = '0;
                end else if (enable && w_level_ok) begin
                    w_state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (frame_start) begin
                    w_fs_pend_nxt = 1'b1;
                end
                if (m_awready) begin
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                if (frame_start) begin
                    w_fs_pend_nxt = 1'b1;
                end
                w_wvalid = !fifo_empty;
                w_wlast  = (r_beat_cnt == LAST_BEAT);
                w_rd_en  = w_wvalid && m_wready;
                if (w_rd_en) begin
                    if (w_wlast) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = ST_RESP;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                    end
                end
            end

            ST_RESP: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        w_resp_err_nxt = 1'b1;
                    end
                    // A restart request (held or arriving now) beats the advance
                    if (r_fs_pend || frame_start || w_frm_wrap) begin
                        w_cur_addr_nxt = BASE_ADDR;
                        w_frm_cnt_nxt  = '0;
                    end else begin
                        w_cur_addr_nxt = r_cur_addr + ADDR_STEP;
                        w_frm_cnt_nxt  = w_frm_sum;
                    end
                    w_frame_done_nxt = w_frm_wrap;
                    w_fs_pend_nxt    = 1'b0;
                    w_state_nxt      = ST_IDLE;
                end else if (frame_start) begin
                    w_fs_pend_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // AW fields come straight from registers, so they hold during stalls
    assign m_awvalid  = (r_state == ST_ADDR);
    assign m_awaddr   = r_cur_addr;
    assign m_awlen    = LAST_BEAT;

    // Prefetch FIFO: head word is presented directly and popped on handshake
    assign m_wvalid   = w_wvalid;
    assign m_wdata    = fifo_rd_data;
    assign m_wstrb    = {STRB_W{1'b1}};
    assign m_wlast    = w_wlast;
    assign fifo_rd_en = w_rd_en;

    assign m_bready   = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for ddr_wr_burst_ctrl with a transaction-level reference
// model: expected addresses, data order, frame_done and resp_err are derived
// from burst/frame arithmetic, checked every cycle on the falling edge.
module tb_ddr_wr_burst_ctrl;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 28;
    localparam int unsigned LW = 8;
    localparam int unsigned BL = 16;
    localparam int unsigned FB = 32;
    localparam logic [AW-1:0] BASE = '0;
    localparam logic [AW-1:0] STEP = AW'(BL * DW / 8);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              frame_start;
    logic              fifo_rd_en;
    logic [DW-1:0]     fifo_rd_data;
    logic              fifo_empty;
    logic [LW-1:0]     fifo_rd_level;
    logic [AW-1:0]     m_awaddr;
    logic [7:0]        m_awlen;
    logic              m_awvalid;
    logic              m_awready;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_wlast;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic              busy;
    logic              frame_done;
    logic              resp_err;

    always #5 clk = ~clk;

    ddr_wr_burst_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LVL_WIDTH  (LW),
        .BURST_LEN  (BL),
        .BASE_ADDR  (BASE),
        .FRAME_BEATS(FB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_start  (frame_start),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_level(fifo_rd_level),
        .m_awaddr     (m_awaddr),
        .m_awlen      (m_awlen),
        .m_awvalid    (m_awvalid),
        .m_awready    (m_awready),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_wlast      (m_wlast),
        .m_wvalid     (m_wvalid),
        .m_wready     (m_wready),
        .m_bresp      (m_bresp),
        .m_bvalid     (m_bvalid),
        .m_bready     (m_bready),
        .busy         (busy),
        .frame_done   (frame_done),
        .resp_err     (resp_err)
    );

    // ---------------- stimulus-side state (written by the main process) ----
    logic [DW-1:0] q[$];
    int            push_cnt = 0;
    int            to_cnt = 0;
    logic          sim_done = 1'b0;
    int unsigned   aw_mode = 0;
    int unsigned   w_prob = 100;
    int unsigned   b_prob = 100;
    logic [1:0]    bresp_val = 2'b00;

    // ---------------- checker-side state (written by the compare process) --
    int            checks = 0;
    int            errors = 0;
    int            cycles = 0;
    logic          pop_flag = 1'b0;
    logic          in_data = 1'b0;
    logic          in_resp = 1'b0;
    int            beat = 0;
    int            aw_cnt = 0;
    int            w_cnt = 0;
    int            b_cnt = 0;
    int            fd_cnt = 0;
    logic [AW-1:0] exp_addr = BASE;
    int            exp_frm = 0;
    logic          pend = 1'b0;
    logic          exp_fd = 1'b0;
    logic          exp_err = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_busy = 1'b0;
    logic          prev_start = 1'b0;
    logic          prev_aw_stall = 1'b0;
    logic          prev_w_stall = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;
    logic [DW-1:0] prev_wdata = '0;
    logic          aw_hs, w_hs, b_hs, e_awvalid, e_busy, complete;

    function automatic logic [DW-1:0] mkword(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = 32'(n * 8 + i) ^ 32'h5A00_0000;
        return w;
    endfunction

    // Hand-computed burst addresses for the directed part of the run
    function automatic logic [AW-1:0] lit_addr(input int i);
        case (i)
            1, 3, 7: return AW'(28'h200);
            default: return AW'(28'h000);
        endcase
    endfunction

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        cycles++;
        if (sim_done || cycles > 30000) begin
            checks++;
            if (!sim_done) begin
                errors++;
                $display("FAIL watchdog: got %0d cycles expected end of stimulus", cycles);
            end
            chk("timeouts", DW'(to_cnt), DW'(0));
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else if (!rst_n) begin
            chk("rst_ctrl", DW'({m_awvalid, m_wvalid, m_wlast, m_bready, fifo_rd_en, busy, frame_done, resp_err}), DW'(0));
            chk("rst_awaddr", DW'(m_awaddr), DW'(BASE));
            chk("rst_awlen", DW'(m_awlen), DW'(BL - 1));
            exp_addr = BASE; exp_frm = 0; pend = 1'b0; in_data = 1'b0; in_resp = 1'b0;
            beat = 0; exp_fd = 1'b0; exp_err = 1'b0; prev_valid = 1'b0; pop_flag = 1'b0;
        end else begin
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            e_awvalid = !prev_valid ? 1'b0 : (prev_busy ? prev_aw_stall : prev_start);
            e_busy    = e_awvalid || in_data || in_resp;

            chk("awvalid", DW'(m_awvalid), DW'(e_awvalid));
            chk("busy", DW'(busy), DW'(e_busy));
            chk("bready", DW'(m_bready), DW'(in_resp));
            chk("wvalid", DW'(m_wvalid), DW'(in_data && !fifo_empty));
            chk("wlast", DW'(m_wlast), DW'(in_data && beat == BL - 1));
            chk("fifo_rd_en", DW'(fifo_rd_en), DW'(in_data && !fifo_empty && m_wready));
            chk("frame_done", DW'(frame_done), DW'(exp_fd));
            chk("resp_err", DW'(resp_err), DW'(exp_err));
            if (prev_aw_stall) chk("aw_stable", DW'(m_awaddr), DW'(prev_awaddr));
            if (prev_w_stall) chk("w_stable", m_wdata, prev_wdata);

            if (frame_done) fd_cnt++;

            if (w_hs) begin
                chk("wdata", m_wdata, mkword(w_cnt));
                chk("wstrb", DW'(m_wstrb), DW'({(DW/8){1'b1}}));
                w_cnt++;
                if (beat == BL - 1) begin
                    beat = 0; in_data = 1'b0; in_resp = 1'b1;
                end else begin
                    beat++;
                end
            end

            if (aw_hs) begin
                chk("awaddr", DW'(m_awaddr), DW'(exp_addr));
                chk("awlen", DW'(m_awlen), DW'(BL - 1));
                if (aw_cnt < 9) chk("awaddr_lit", DW'(m_awaddr), DW'(lit_addr(aw_cnt)));
                if (aw_cnt == 8) chk("frame_done_cnt", DW'(fd_cnt), DW'(3));
                aw_cnt++;
                in_data = 1'b1;
            end

            exp_fd = 1'b0;
            if (b_hs) begin
                complete = (exp_frm + int'(BL) >= int'(FB));
                if (m_bresp != 2'b00) exp_err = 1'b1;
                if (pend || frame_start || complete) begin
                    exp_addr = BASE; exp_frm = 0;
                end else begin
                    exp_addr = exp_addr + STEP; exp_frm = exp_frm + int'(BL);
                end
                exp_fd = complete;
                pend = 1'b0;
                in_resp = 1'b0;
                b_cnt++;
            end else if (frame_start) begin
                if (!e_busy) begin
                    exp_addr = BASE; exp_frm = 0;
                end else begin
                    pend = 1'b1;
                end
            end

            prev_valid    = 1'b1;
            prev_busy     = e_busy;
            prev_start    = enable && (int'(fifo_rd_level) >= int'(BL)) && !frame_start;
            prev_aw_stall = m_awvalid && !m_awready;
            prev_awaddr   = m_awaddr;
            prev_w_stall  = m_wvalid && !m_wready;
            prev_wdata    = m_wdata;
            pop_flag      = fifo_rd_en;
        end
    end

    // ---------------- stimulus ----------------
    function automatic void fifo_update();
        fifo_empty    = (q.size() == 0);
        fifo_rd_level = LW'(q.size());
        fifo_rd_data  = (q.size() > 0) ? q[0] : '0;
    endfunction

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            q.push_back(mkword(push_cnt));
            push_cnt++;
        end
        fifo_update();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_flag && q.size() > 0) void'(q.pop_front());
        case (aw_mode)
            0:       m_awready = 1'b1;
            1:       m_awready = ($urandom_range(0, 99) < 60);
            default: m_awready = 1'b0;
        endcase
        m_wready = ($urandom_range(0, 99) < w_prob);
        m_bvalid = in_resp && ($urandom_range(0, 99) < b_prob);
        m_bresp  = m_bvalid ? bresp_val : 2'b00;
        fifo_update();
    endtask

    task automatic wait_b(input int n);
        int k = 0;
        while (b_cnt < n && k < 1000) begin tick(); k++; end
        if (b_cnt < n) to_cnt++;
    endtask

    task automatic wait_w(input int n);
        int k = 0;
        while (w_cnt < n && k < 1000) begin tick(); k++; end
        if (w_cnt < n) to_cnt++;
    endtask

    initial begin
        int k;
        rst_n = 1'b1; enable = 1'b0; frame_start = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        fifo_update();
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // basic burst, all readys high
        enable = 1'b1;
        push(16);
        wait_b(1);

        // level threshold: 15 words never start a burst, the 16th does
        push(15);
        repeat (6) tick();
        push(1);
        wait_b(2);

        // AW held off, random W backpressure
        aw_mode = 2; w_prob = 50;
        push(16);
        repeat (7) tick();
        aw_mode = 0;
        wait_b(3);

        // random AW/W/B readiness, completes the frame
        aw_mode = 1; w_prob = 80; b_prob = 40;
        push(16);
        wait_b(4);

        // frame_start in the middle of a burst's data phase
        aw_mode = 0; w_prob = 60; b_prob = 100;
        push(16);
        wait_w(w_cnt + 5);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_b(5);

        // reset in the middle of a burst's data phase
        w_prob = 100;
        push(16);
        wait_w(w_cnt + 6);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        push(16 - q.size());
        wait_b(6);

        // error response, then a clean one: resp_err stays set
        bresp_val = 2'b10;
        push(16);
        wait_b(7);
        bresp_val = 2'b00;
        push(16);
        wait_b(8);

        // random soak
        aw_mode = 1; w_prob = 70; b_prob = 50;
        for (int c = 0; c < 1500; c++) begin
            enable      = ($urandom_range(0, 7) != 0);
            frame_start = ($urandom_range(0, 59) == 0);
            if (q.size() < 120 && $urandom_range(0, 3) == 0) push(int'($urandom_range(1, 8)));
            tick();
        end

        // drain and finish with a final reset
        enable = 1'b0; frame_start = 1'b0;
        aw_mode = 0; w_prob = 100; b_prob = 100;
        push(16);
        k = 0;
        while (busy && k < 500) begin tick(); k++; end
        if (busy) to_cnt++;
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        sim_done = 1'b1;
        tick();
    end

endmodule
